// File: rtl/clk_meas_pkg.sv
`default_nettype none
// ============================================================================
// Package     : clk_meas_pkg
// Description : Shared types and defaults for the clock edge measurement
//               block: measurement FSM state encoding and the default
//               counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_meas_pkg;

  // Default width of the cycle counter and of the measurement outputs.
  localparam int CNT_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } meas_state_t;

endpackage : clk_meas_pkg
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : sync_edge
// Description : Brings an asynchronous slow clock level into the clock
//               domain through a flop chain, keeps a registered copy, and
//               derives one-cycle rising/falling strobes that lead the
//               registered level by one cycle.
// Ports       : clock      - system clock
//               reset      - asynchronous active-low reset
//               ext_clk    - asynchronous level, sampled only
//               level      - synchronized, registered copy of ext_clk
//               pos_change - level is 0 now and becomes 1 next cycle
//               neg_change - level is 1 now and becomes 0 next cycle
// Revision    : 1.0 - initial release
// ============================================================================
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic ext_clk,
  output logic level,
  output logic pos_change,
  output logic neg_change
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("sync_edge: SYNC_STAGES must be in 2..4");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_q;
  logic                   sync_w;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ext_clk};
      level_q <= sync_w;
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  // The strobes compare the last sync stage with the level register, so they
  // announce the change one cycle before level shows it. Both come from the
  // same two flops and are mutually exclusive by construction.
  assign pos_change = sync_w & ~level_q;
  assign neg_change = ~sync_w & level_q;
  assign level      = level_q;

endmodule : sync_edge
`default_nettype wire

// File: rtl/clock_edge_meas.sv
`default_nettype none
// ============================================================================
// Module      : clock_edge_meas
// Description : Receive-side counterpart of a clock divider. Synchronizes a
//               slow external clock level, regenerates pos/neg change
//               strobes, measures period and high time in clock cycles, and
//               flags a stopped input.
// Ports       : clock      - system clock
//               reset      - asynchronous active-low reset
//               ext_clk    - asynchronous slow clock level (sampled only)
//               level      - synchronized copy of ext_clk
//               pos_change - one-cycle rising strobe
//               neg_change - one-cycle falling strobe
//               period     - cycles between the last two rising edges
//               high_time  - cycles high within that period
//               meas_valid - one-cycle pulse when period/high_time update
//               locked     - a full period has been measured since reset or
//                            the last stall
//               stalled    - no rising edge for MAX_COUNT cycles
// Revision    : 1.0 - initial release
// ============================================================================
module clock_edge_meas
  import clk_meas_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter int          CNT_WIDTH   = CNT_WIDTH_DEFAULT,
  parameter int unsigned MAX_COUNT   = (2 ** CNT_WIDTH) - 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ext_clk,
  output logic                 level,
  output logic                 pos_change,
  output logic                 neg_change,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 meas_valid,
  output logic                 locked,
  output logic                 stalled
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_COUNT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 pos_w;
  logic                 neg_w;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] cnt_inc_w;
  logic [CNT_WIDTH-1:0] hi_acc_q;
  logic [CNT_WIDTH-1:0] period_q;
  logic [CNT_WIDTH-1:0] high_time_q;
  logic                 meas_valid_q;
  logic                 locked_q;
  logic                 stalled_q;
  meas_state_t          state_q;

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clock      (clock),
    .reset      (reset),
    .ext_clk    (ext_clk),
    .level      (level),
    .pos_change (pos_w),
    .neg_change (neg_w)
  );

  // cnt+1 deliberately wraps in CNT_WIDTH bits: with MAX_COUNT at the
  // all-ones default, a period of 2**CNT_WIDTH cycles reads back as 0.
  assign cnt_inc_w = cnt_q + CNT_ONE;

  // Counter restarts on every rising strobe so that at the next rising strobe
  // it holds (period - 1); it saturates rather than wrapping so a stopped
  // input is detected by reaching CNT_MAX.
  always_comb begin
    cnt_d = cnt_inc_w;
    if (pos_w) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      hi_acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (neg_w) begin
        hi_acc_q <= cnt_inc_w;
      end
    end
  end

  // Measurement FSM. The first rising edge only arms (no complete period
  // yet); later edges report. An edge in the same cycle the counter hits
  // CNT_MAX takes priority, so a period of exactly MAX_COUNT+1 is measured.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      stalled_q    <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      if (pos_w) begin
        stalled_q <= 1'b0;
        unique case (state_q)
          IDLE: begin
            state_q <= ARMED;
          end
          ARMED, LOCKED: begin
            state_q      <= LOCKED;
            locked_q     <= 1'b1;
            period_q     <= cnt_inc_w;
            high_time_q  <= hi_acc_q;
            meas_valid_q <= 1'b1;
          end
          default: begin
            state_q  <= IDLE;
            locked_q <= 1'b0;
          end
        endcase
      end else if ((cnt_q == CNT_MAX) && (state_q != IDLE)) begin
        // period and high_time are intentionally left holding the last report.
        state_q   <= IDLE;
        locked_q  <= 1'b0;
        stalled_q <= 1'b1;
      end
    end
  end

  assign pos_change = pos_w;
  assign neg_change = neg_w;
  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign stalled    = stalled_q;

endmodule : clock_edge_meas
`default_nettype wire

// File: tb/tb_clock_edge_meas.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_edge_meas
// Description : Self-checking bench for clock_edge_meas. Drives directed and
//               random ext_clk waveforms and compares every output each cycle
//               against a timestamp-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_edge_meas;

  localparam int S    = 2;
  localparam int W    = 16;
  localparam int MAXC = 20;

  logic         clock   = 1'b0;
  logic         reset   = 1'b0;
  logic         ext_clk = 1'b0;
  logic         level;
  logic         pos_change;
  logic         neg_change;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         locked;
  logic         stalled;

  always #5 clock = ~clock;

  clock_edge_meas #(
    .SYNC_STAGES (S),
    .CNT_WIDTH   (W),
    .MAX_COUNT   (MAXC)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .ext_clk    (ext_clk),
    .level      (level),
    .pos_change (pos_change),
    .neg_change (neg_change),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .stalled    (stalled)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: ext_clk sample history plus timestamps of strobes.
  bit     h[$];
  longint k;
  int     edges;      // rising strobes since reset/stall, capped at 2
  longint tpos;       // cycle index of the last rising strobe
  longint hi;         // high duration recorded at the last falling strobe
  bit     e_valid;
  bit     e_stalled;
  longint e_period;
  longint e_high;

  function automatic bit hist(input longint i);
    if (i < 0 || i >= longint'(h.size())) return 1'b0;
    return h[i];
  endfunction

  task automatic model_reset();
    h.delete();
    k         = 0;
    edges     = 0;
    tpos      = -2;   // counter leaves reset at 0 and reads 1 after edge 0
    hi        = 0;
    e_valid   = 1'b0;
    e_stalled = 1'b0;
    e_period  = 0;
    e_high    = 0;
  endtask

  // One clock cycle: record the value captured at this edge, compare every
  // output, advance the model, then present the next ext_clk value.
  task automatic tick(input bit v);
    bit     lv, sy, ps, ng;
    longint since;
    @(negedge clock);
    h.push_back(ext_clk);
    lv = hist(k - S);
    sy = hist(k - S + 1);
    ps = sy & ~lv;
    ng = ~sy & lv;
    check_eq("level",      level,      lv);
    check_eq("pos_change", pos_change, ps);
    check_eq("neg_change", neg_change, ng);
    check_eq("meas_valid", meas_valid, e_valid);
    check_eq("locked",     locked,     edges == 2);
    check_eq("stalled",    stalled,    e_stalled);
    check_eq("period",     period,     e_period);
    check_eq("high_time",  high_time,  e_high);

    // Cycles elapsed since the last rising strobe, clipped at the stall limit.
    since = k - tpos;
    if (since > MAXC + 1) since = MAXC + 1;
    e_valid = 1'b0;
    if (ps) begin
      e_stalled = 1'b0;
      if (edges >= 1) begin
        e_period = since % (64'd1 << W);
        e_high   = hi;
        e_valid  = 1'b1;
        edges    = 2;
      end else begin
        edges = 1;
      end
      tpos = k;
    end else if (edges >= 1 && since == MAXC + 1) begin
      edges     = 0;
      e_stalled = 1'b1;
    end
    if (ng) hi = since % (64'd1 << W);
    k++;
    ext_clk = v;
  endtask

  task automatic run_clk(input int hi_c, input int lo_c, input int n);
    repeat (n) begin
      repeat (hi_c) tick(1'b1);
      repeat (lo_c) tick(1'b0);
    end
  endtask

  // Asserts reset between clock edges and checks that outputs clear at once.
  task automatic apply_reset();
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check_eq("rst_level",      level,      0);
    check_eq("rst_meas_valid", meas_valid, 0);
    check_eq("rst_locked",     locked,     0);
    check_eq("rst_stalled",    stalled,    0);
    check_eq("rst_period",     period,     0);
    check_eq("rst_high_time",  high_time,  0);
    repeat (3) @(negedge clock);
    ext_clk = 1'b0;
    reset   = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    apply_reset();

    // 50% duty, period 8.
    repeat (3) tick(1'b0);
    run_clk(4, 4, 5);
    // 3 high / 5 low.
    run_clk(3, 5, 5);
    // Rising edge then held high long enough to stall.
    repeat (4) tick(1'b0);
    repeat (30) tick(1'b1);
    repeat (4) tick(1'b0);
    // Resume after stall.
    run_clk(4, 4, 4);
    // Period exactly MAX_COUNT+1, then one cycle longer, then back.
    run_clk(10, 11, 3);
    run_clk(11, 11, 3);
    run_clk(10, 11, 3);
    // Random high/low widths; long ones occasionally stall.
    repeat (40) begin
      int hc, lc;
      hc = int'($urandom_range(1, 14));
      lc = int'($urandom_range(1, 14));
      run_clk(hc, lc, 1);
    end
    // Reset in the middle of a period while locked.
    repeat (2) tick(1'b0);
    run_clk(4, 4, 3);
    repeat (2) tick(1'b1);
    apply_reset();
    repeat (2) tick(1'b0);
    run_clk(4, 4, 4);
    repeat (4) tick(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_clock_edge_meas
`default_nettype wire
